// File: rtl/reset_seq.sv
// Multi-domain reset sequencer: asserts all channels together, holds them LENGTH
// cycles after the last request, then releases them STAGGER cycles apart, channel 0 first.
module reset_seq #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned LENGTH   = 4,
    parameter int unsigned STAGGER  = 2
) (
    input  logic                ck,
    input  logic                rst,
    input  logic                rst_req,
    input  logic                sw_req,
    output logic [CHANNELS-1:0] rst_ch,
    output logic                busy,
    output logic [1:0]          cause
);

    localparam int unsigned MAXV = (LENGTH > STAGGER) ? LENGTH : STAGGER;
    localparam int unsigned CW   = $clog2(MAXV + 1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [CHANNELS-1:0]   ch_n;
    logic                  busy_n;
    logic [1:0]            cause_n;
    logic                  sync1, sync_rst;
    logic                  req;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync_rst <= 1'b1;
        end else begin
            sync1    <= 1'b0;
            sync_rst <= sync1;
        end
    end

    assign req = sync_rst | rst_req | sw_req;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= HOLD;
            cnt    <= '0;
            rst_ch <= '1;
            busy   <= 1'b1;
            cause  <= 2'd0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rst_ch <= ch_n;
            busy   <= busy_n;
            cause  <= cause_n;
        end
    end

    // Channels release by shifting zeros in from bit 0, so the low-first
    // release order holds without a separate channel index.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ch_n    = rst_ch;
        cause_n = cause;

        if (rst_req)
            cause_n = 2'd1;
        else if (sw_req)
            cause_n = 2'd2;

        if (req) begin
            state_n = HOLD;
            cnt_n   = '0;
            ch_n    = '1;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt + CW'(1) == CW'(LENGTH)) begin
                        ch_n    = rst_ch << 1;
                        cnt_n   = '0;
                        state_n = (ch_n == '0) ? RUN : RELEASE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt + CW'(1) == CW'(STAGGER)) begin
                        ch_n    = rst_ch << 1;
                        cnt_n   = '0;
                        state_n = (ch_n == '0) ? RUN : RELEASE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                RUN: begin
                    ch_n = '0;
                end
                default: begin
                    state_n = HOLD;
                    cnt_n   = '0;
                    ch_n    = '1;
                end
            endcase
        end

        busy_n = |ch_n;
    end

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: three parameterisations share one stimulus stream;
// expected outputs come from release-edge arithmetic relative to the last request edge.
module tb_reset_seq;

    logic       ck = 1'b0;
    logic       rst, rst_req, sw_req;
    logic [2:0] ch_a;
    logic [0:0] ch_b;
    logic [7:0] ch_c;
    logic       busy_a, busy_b, busy_c;
    logic [1:0] cause_a, cause_b, cause_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a, b, c;
        logic [1:0] cause;
    } exp_t;

    exp_t sb[$];

    always #5 ck = ~ck;

    reset_seq #(.CHANNELS(3), .LENGTH(4), .STAGGER(2)) u_a (
        .ck(ck), .rst(rst), .rst_req(rst_req), .sw_req(sw_req),
        .rst_ch(ch_a), .busy(busy_a), .cause(cause_a));

    reset_seq #(.CHANNELS(1), .LENGTH(1), .STAGGER(1)) u_b (
        .ck(ck), .rst(rst), .rst_req(rst_req), .sw_req(sw_req),
        .rst_ch(ch_b), .busy(busy_b), .cause(cause_b));

    reset_seq #(.CHANNELS(8), .LENGTH(17), .STAGGER(3)) u_c (
        .ck(ck), .rst(rst), .rst_req(rst_req), .sw_req(sw_req),
        .rst_ch(ch_c), .busy(busy_c), .cause(cause_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel k is high after edge n while n < last_req_edge + LENGTH + k*STAGGER.
    function automatic logic [7:0] exp_ch(int n, int l, int len, int stg, int nch);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < nch; k++)
            v[k] = (n < l + len + k * stg);
        return v;
    endfunction

    int   n = 0, l = 0, srst = 2;
    logic [1:0] mcause = 2'd0;

    initial forever begin
        exp_t e;
        bit   rq;
        @(posedge ck);
        if (rst) begin
            n = 0; l = 0; srst = 2; mcause = 2'd0;
        end else begin
            n++;
            rq = (srst > 0) || rst_req || sw_req;
            if (srst > 0) srst--;
            if (rq) l = n;
            if (rst_req) mcause = 2'd1;
            else if (sw_req) mcause = 2'd2;
        end
        e.a     = exp_ch(n, l, 4, 2, 3);
        e.b     = exp_ch(n, l, 1, 1, 1);
        e.c     = exp_ch(n, l, 17, 3, 8);
        e.cause = mcause;
        sb.push_back(e);
    end

    initial forever begin
        exp_t e;
        @(negedge ck);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ch_a",    32'(ch_a),    32'(e.a[2:0]));
            check("busy_a",  32'(busy_a),  32'(|e.a));
            check("cause_a", 32'(cause_a), 32'(e.cause));
            check("ch_b",    32'(ch_b),    32'(e.b[0]));
            check("busy_b",  32'(busy_b),  32'(e.b[0]));
            check("cause_b", 32'(cause_b), 32'(e.cause));
            check("ch_c",    32'(ch_c),    32'(e.c));
            check("busy_c",  32'(busy_c),  32'(|e.c));
            check("cause_c", 32'(cause_c), 32'(e.cause));
        end
    end

    initial begin
        rst = 1'b1; rst_req = 1'b0; sw_req = 1'b0;
        #1;
        check("por_ch_a",    32'(ch_a),    32'h7);
        check("por_cause_a", 32'(cause_a), 32'h0);
        repeat (3) @(negedge ck);
        rst = 1'b0;
        repeat (12) @(negedge ck);

        rst_req = 1'b1;
        repeat (25) @(negedge ck);
        rst_req = 1'b0;
        repeat (12) @(negedge ck);

        sw_req = 1'b1;
        @(negedge ck);
        sw_req = 1'b0;
        repeat (12) @(negedge ck);

        // abort: sw pulse, then rst_req sampled between ch0 and ch1 release
        sw_req = 1'b1;
        @(negedge ck);
        sw_req = 1'b0;
        repeat (4) @(negedge ck);
        rst_req = 1'b1;
        @(negedge ck);
        rst_req = 1'b0;
        repeat (14) @(negedge ck);

        rst_req = 1'b1; sw_req = 1'b1;
        @(negedge ck);
        rst_req = 1'b0; sw_req = 1'b0;
        repeat (5) @(negedge ck);

        // async reset mid-release, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        check("async_ch_a",    32'(ch_a),    32'h7);
        check("async_busy_a",  32'(busy_a),  32'h1);
        check("async_cause_a", 32'(cause_a), 32'h0);
        check("async_ch_c",    32'(ch_c),    32'hff);
        check("async_cause_c", 32'(cause_c), 32'h0);
        repeat (2) @(negedge ck);
        rst = 1'b0;
        repeat (45) @(negedge ck);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
